// File: rtl/usb_rx_buffer.sv
// usb_rx_buffer
// Receive-side byte FIFO between the usb_uart OUT-endpoint stream and slow
// user logic. The head byte is presented on a level-valid output, and one
// byte is consumed per rising edge of usb_rx_read. When the FIFO is full,
// uart_out_ready drops so that usb_uart NAKs the host; no byte is dropped.
//
// Optional feature macro: USB_RX_LINE_EN
//   defined   -> usb_rx_lines counts buffered LINE_CHAR bytes
//   undefined -> usb_rx_lines is tied to zero and no line logic is built
module usb_rx_buffer #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] LINE_CHAR  = 8'h0A
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  input  logic [7:0]            uart_out_data,
  input  logic                  uart_out_valid,
  output logic                  uart_out_ready,
  output logic [7:0]            usb_rx_data,
  output logic                  usb_rx_valid,
  input  logic                  usb_rx_read,
  input  logic                  usb_rx_flush,
  output logic [DEPTH_LOG2:0]   usb_rx_count,
  output logic [DEPTH_LOG2:0]   usb_rx_lines
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Storage and pointers
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_read_d;

  // Handshake and control decode
  logic       w_full;
  logic       w_empty;
  logic       w_ready;
  logic       w_push;
  logic       w_pop_edge;
  logic       w_pop;
  logic [7:0] w_head;

  assign w_full     = (r_count == FULL_COUNT);
  assign w_empty    = (r_count == '0);

  // Ready looks only at registers, reset and flush, never at uart_out_valid,
  // so there is no combinational loop through the usb_uart handshake.
  assign w_ready    = reset_n & ~w_full & ~usb_rx_flush;
  assign w_push     = uart_out_valid & w_ready;

  // A pop is a rising edge of the read strobe; an edge seen while empty is
  // simply lost rather than remembered for later.
  assign w_pop_edge = usb_rx_read & ~r_read_d;
  assign w_pop      = w_pop_edge & ~w_empty & ~usb_rx_flush;

  assign w_head     = r_mem[r_rd_ptr];

  assign uart_out_ready = w_ready;
  assign usb_rx_valid   = ~w_empty;
  assign usb_rx_data    = w_empty ? 8'h00 : w_head;
  assign usb_rx_count   = r_count;

  // Byte storage: write the accepted byte at the write pointer
  always_ff @(posedge clk_48mhz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= uart_out_data;
    end
  end

  // Read-strobe history; forced high in reset so a read held through reset
  // does not look like a fresh edge once reset is released
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_read_d <= 1'b1;
    end else begin
      r_read_d <= usb_rx_read;
    end
  end

  // Pointer and occupancy tracking; flush outranks push and pop
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (usb_rx_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef USB_RX_LINE_EN
  // Line-terminator bookkeeping
  logic                r_lines;
  logic [DEPTH_LOG2:0] r_line_count;
  logic                w_push_line;
  logic                w_pop_line;

  assign w_push_line = w_push & (uart_out_data == LINE_CHAR);
  assign w_pop_line  = w_pop & (w_head == LINE_CHAR);

  // Count terminators in flight; a terminator in and out together cancel
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_line_count <= '0;
    end else if (usb_rx_flush) begin
      r_line_count <= '0;
    end else begin
      case ({w_push_line, w_pop_line})
        2'b10:   r_line_count <= r_line_count + 1'b1;
        2'b01:   r_line_count <= r_line_count - 1'b1;
        default: r_line_count <= r_line_count;
      endcase
    end
  end

  // Flag kept only to mirror the count for local debug visibility
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_lines <= 1'b0;
    end else begin
      r_lines <= (r_line_count != '0);
    end
  end

  assign usb_rx_lines = r_line_count;
`else
  assign usb_rx_lines = '0;
`endif

endmodule

// File: tb/tb_usb_rx_buffer.sv
// Directed self-checking bench for usb_rx_buffer (DEPTH_LOG2 = 4).
module tb_usb_rx_buffer;

  logic       clk_48mhz;
  logic       reset_n;
  logic [7:0] uart_out_data;
  logic       uart_out_valid;
  logic       uart_out_ready;
  logic [7:0] usb_rx_data;
  logic       usb_rx_valid;
  logic       usb_rx_read;
  logic       usb_rx_flush;
  logic [4:0] usb_rx_count;
  logic [4:0] usb_rx_lines;

  int checks = 0;
  int errors = 0;

`ifdef USB_RX_LINE_EN
  localparam bit LINE_EN = 1'b1;
`else
  localparam bit LINE_EN = 1'b0;
`endif

  usb_rx_buffer #(
    .DEPTH_LOG2(4),
    .LINE_CHAR (8'h0A)
  ) dut (
    .clk_48mhz     (clk_48mhz),
    .reset_n       (reset_n),
    .uart_out_data (uart_out_data),
    .uart_out_valid(uart_out_valid),
    .uart_out_ready(uart_out_ready),
    .usb_rx_data   (usb_rx_data),
    .usb_rx_valid  (usb_rx_valid),
    .usb_rx_read   (usb_rx_read),
    .usb_rx_flush  (usb_rx_flush),
    .usb_rx_count  (usb_rx_count),
    .usb_rx_lines  (usb_rx_lines)
  );

  initial clk_48mhz = 1'b0;
  always #10 clk_48mhz = ~clk_48mhz;

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk_48mhz);
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded wait)
  task automatic push_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    uart_out_data  = b;
    uart_out_valid = 1'b1;
    #1;
    while (!uart_out_ready && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (!uart_out_ready) begin
      errors++;
      $display("FAIL push_timeout: ready=%b required 1 for byte %h", uart_out_ready, b);
    end else begin
      tick();
      $display("push %h count=%0d", b, usb_rx_count);
    end
    uart_out_valid = 1'b0;
  endtask

  // One read pulse: high for a cycle, then low for a cycle
  task automatic pop_pulse();
    usb_rx_read = 1'b1;
    tick();
    usb_rx_read = 1'b0;
    tick();
    $display("pop  count=%0d head=%h", usb_rx_count, usb_rx_data);
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    usb_rx_read    = 1'b1;
    usb_rx_flush   = 1'b0;
    uart_out_valid = 1'b0;
    uart_out_data  = 8'h00;
    repeat (3) tick();
    checks++;
    if (uart_out_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", uart_out_ready); end
    checks++;
    if (usb_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", usb_rx_valid); end
    checks++;
    if (usb_rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", usb_rx_data); end
    checks++;
    if (usb_rx_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", usb_rx_count); end
    checks++;
    if (usb_rx_lines !== 5'd0) begin errors++; $display("FAIL reset_lines: got %0d required 0", usb_rx_lines); end
    reset_n = 1'b1;
    tick();
    checks++;
    if (uart_out_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", uart_out_ready); end
    push_byte(8'h41);
    checks++;
    if (usb_rx_valid !== 1'b1 || usb_rx_data !== 8'h41 || usb_rx_count !== 5'd1) begin
      errors++;
      $display("FAIL reset_push: valid=%b data=%h count=%0d required 1/41/1", usb_rx_valid, usb_rx_data, usb_rx_count);
    end
    repeat (5) tick();
    checks++;
    if (usb_rx_count !== 5'd1) begin errors++; $display("FAIL held_read_no_pop: count=%0d required 1", usb_rx_count); end
    usb_rx_read = 1'b0;
    tick();
    usb_rx_read = 1'b1;
    tick();
    checks++;
    if (usb_rx_count !== 5'd0 || usb_rx_valid !== 1'b0 || usb_rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_first_pop: count=%0d valid=%b data=%h required 0/0/00", usb_rx_count, usb_rx_valid, usb_rx_data);
    end
    usb_rx_read = 1'b0;
    tick();
  endtask

  task automatic test_fill_wrap();
    logic [7:0] exp_b;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    checks++;
    if (usb_rx_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d required 16", usb_rx_count); end
    uart_out_data  = 8'h10;
    uart_out_valid = 1'b1;
    tick();
    checks++;
    if (uart_out_ready !== 1'b0 || usb_rx_count !== 5'd16) begin
      errors++;
      $display("FAIL full_block: ready=%b count=%0d required 0/16", uart_out_ready, usb_rx_count);
    end
    checks++;
    if (usb_rx_data !== 8'h00) begin errors++; $display("FAIL full_head: got %h required 00", usb_rx_data); end
    // First pop while the 8'h10 offer stays valid
    usb_rx_read = 1'b1;
    tick();
    checks++;
    if (uart_out_ready !== 1'b1 || usb_rx_count !== 5'd15 || usb_rx_data !== 8'h01) begin
      errors++;
      $display("FAIL full_pop_ready: ready=%b count=%0d data=%h required 1/15/01", uart_out_ready, usb_rx_count, usb_rx_data);
    end
    usb_rx_read = 1'b0;
    tick();
    uart_out_valid = 1'b0;
    checks++;
    if (usb_rx_count !== 5'd16) begin errors++; $display("FAIL refill_count: got %0d required 16", usb_rx_count); end
    for (int i = 1; i <= 16; i++) begin
      exp_b = 8'(i);
      checks++;
      if (usb_rx_valid !== 1'b1 || usb_rx_data !== exp_b) begin
        errors++;
        $display("FAIL drain_order: valid=%b data=%h required 1/%h", usb_rx_valid, usb_rx_data, exp_b);
      end
      pop_pulse();
    end
    checks++;
    if (usb_rx_count !== 5'd0 || usb_rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: count=%0d valid=%b required 0/0", usb_rx_count, usb_rx_valid);
    end
    // A pop edge while empty must not be remembered
    pop_pulse();
    push_byte(8'h99);
    checks++;
    if (usb_rx_count !== 5'd1 || usb_rx_data !== 8'h99) begin
      errors++;
      $display("FAIL empty_pop_ignored: count=%0d data=%h required 1/99", usb_rx_count, usb_rx_data);
    end
    pop_pulse();
  endtask

  task automatic test_long_read();
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    usb_rx_read = 1'b1;
    repeat (100) tick();
    checks++;
    if (usb_rx_count !== 5'd2 || usb_rx_data !== 8'hA2) begin
      errors++;
      $display("FAIL long_read: count=%0d data=%h required 2/A2", usb_rx_count, usb_rx_data);
    end
    usb_rx_read = 1'b0;
    tick();
    pop_pulse();
    pop_pulse();
    checks++;
    if (usb_rx_count !== 5'd0) begin errors++; $display("FAIL long_read_drain: count=%0d required 0", usb_rx_count); end
  endtask

  task automatic test_simultaneous();
    push_byte(8'h55);
    usb_rx_read    = 1'b1;
    uart_out_data  = 8'h66;
    uart_out_valid = 1'b1;
    tick();
    uart_out_valid = 1'b0;
    usb_rx_read    = 1'b0;
    checks++;
    if (usb_rx_count !== 5'd1 || usb_rx_data !== 8'h66) begin
      errors++;
      $display("FAIL simul_push_pop: count=%0d data=%h required 1/66", usb_rx_count, usb_rx_data);
    end
    tick();
    pop_pulse();
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    uart_out_data  = 8'h77;
    uart_out_valid = 1'b1;
    usb_rx_flush   = 1'b1;
    #1;
    checks++;
    if (uart_out_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b required 0", uart_out_ready); end
    tick();
    usb_rx_flush = 1'b0;
    checks++;
    if (usb_rx_count !== 5'd0 || usb_rx_valid !== 1'b0 || usb_rx_data !== 8'h00) begin
      errors++;
      $display("FAIL flush_clear: count=%0d valid=%b data=%h required 0/0/00", usb_rx_count, usb_rx_valid, usb_rx_data);
    end
    tick();
    uart_out_valid = 1'b0;
    checks++;
    if (usb_rx_count !== 5'd1 || usb_rx_data !== 8'h77) begin
      errors++;
      $display("FAIL flush_then_push: count=%0d data=%h required 1/77", usb_rx_count, usb_rx_data);
    end
    pop_pulse();
  endtask

  task automatic test_lines();
    logic [7:0] msg [6];
    logic [4:0] exp_two;
    logic [4:0] exp_one;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h0A;
    msg[3] = 8'h63; msg[4] = 8'h64; msg[5] = 8'h0A;
    exp_two = LINE_EN ? 5'd2 : 5'd0;
    exp_one = LINE_EN ? 5'd1 : 5'd0;
    for (int i = 0; i < 6; i++) push_byte(msg[i]);
    checks++;
    if (usb_rx_lines !== exp_two || usb_rx_count !== 5'd6) begin
      errors++;
      $display("FAIL lines_push: lines=%0d count=%0d required %0d/6", usb_rx_lines, usb_rx_count, exp_two);
    end
    for (int i = 0; i < 3; i++) pop_pulse();
    checks++;
    if (usb_rx_lines !== exp_one || usb_rx_data !== 8'h63) begin
      errors++;
      $display("FAIL lines_pop: lines=%0d data=%h required %0d/63", usb_rx_lines, usb_rx_data, exp_one);
    end
    usb_rx_flush = 1'b1;
    tick();
    usb_rx_flush = 1'b0;
    checks++;
    if (usb_rx_lines !== 5'd0 || usb_rx_count !== 5'd0) begin
      errors++;
      $display("FAIL lines_flush: lines=%0d count=%0d required 0/0", usb_rx_lines, usb_rx_count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_long_read();
    test_simultaneous();
    test_flush();
    test_lines();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_buffer.md
# usb_rx_buffer

Receive-side companion to the USB serial transmit pipeline. It sits between the `usb_uart` OUT-endpoint byte stream (`uart_out_data`/`uart_out_valid`/`uart_out_ready`) and slow user logic. Bytes from the host are buffered in a small FIFO, and the head byte is presented on a level-valid output. User logic pops one byte per rising edge of a read strobe, so a request held high for many 48 MHz cycles consumes exactly one byte. When `usb_rx_buffer` is full, backpressure is applied to `usb_uart` and the host is NAKed; no byte is ever dropped.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^`DEPTH_LOG2` bytes. Legal range 1..8.
- `LINE_CHAR`, default 8'h0A: line-terminator byte counted when `USB_RX_LINE_EN` is defined.

- `clk_48mhz`  in  1  48 MHz USB clock; sole clock.
- `reset_n`  in  1  synchronous reset, active low.
- `uart_out_data`  in  8  byte from `usb_uart`.
- `uart_out_valid`  in  1  `uart_out_data` valid.
- `uart_out_ready`  out  1  `usb_rx_buffer` accepts a byte this cycle.
- `usb_rx_data`  out  8  head-of-FIFO byte; 8'h00 when `usb_rx_valid`=0.
- `usb_rx_valid`  out  1  FIFO non-empty.
- `usb_rx_read`  in  1  pop request; acts on its rising edge only.
- `usb_rx_flush`  in  1  discard all buffered bytes.
- `usb_rx_count`  out  `DEPTH_LOG2`+1  bytes currently buffered.
- `usb_rx_lines`  out  `DEPTH_LOG2`+1  `LINE_CHAR` bytes currently buffered.

## Operation
- **Storage:** register array of 2^`DEPTH_LOG2` × 8.
  - Write pointer `wr_ptr` and read pointer `rd_ptr` are `DEPTH_LOG2` bits wide and wrap modulo depth.
  - `usb_rx_count` is `DEPTH_LOG2`+1 bits wide.
- **Ready:** `uart_out_ready` = `reset_n` & (`usb_rx_count` != 2^`DEPTH_LOG2`) & !`usb_rx_flush`. It is combinational from registers and inputs.
- **Push:** occurs on a clock edge where `uart_out_valid` & `uart_out_ready`. The byte is written at `wr_ptr`, then `wr_ptr` is incremented.
- **Edge detect:**
  - `read_d` registers `usb_rx_read` every cycle.
  - A pop edge occurs when `usb_rx_read`=1 & `read_d`=0.
- **Pop:** occurs on a pop edge while `usb_rx_valid`=1; `rd_ptr` is incremented.
  - A pop edge while empty is ignored. It is not queued.
- **Count:** `usb_rx_count` is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- **Flush:** has priority over push and pop. It zeroes both pointers, `usb_rx_count` and `usb_rx_lines`. `uart_out_ready`=0 during the flush cycle, so no byte is lost mid-handshake.
- **Reset:** while `reset_n`=0 at an edge, all of the following are set:
  - pointers = 0
  - `usb_rx_count` = 0
  - `usb_rx_lines` = 0
  - `read_d` = 1, so a read held high through reset produces no spurious pop.

  Reset values of outputs:
  - `uart_out_ready` = 0 (whenever `reset_n`=0)
  - `usb_rx_valid` = 0
  - `usb_rx_data` = 8'h00
  - `usb_rx_count` = 0
  - `usb_rx_lines` = 0
- **Full / wrap:** at `usb_rx_count` = 2^`DEPTH_LOG2`, `uart_out_ready`=0. The pointers wrap from 2^`DEPTH_LOG2`−1 to 0.

## Timing
- **Push latency:** for a byte accepted at edge N, `usb_rx_valid`=1 and `usb_rx_data` = that byte in the cycle after edge N.
- **Pop latency:** for a pop edge sampled at edge M, the next byte (or `usb_rx_valid`=0) is visible in the cycle after edge M.
- **Minimum pop spacing:** `usb_rx_read` must be low for at least one sampled cycle between pops. Maximum pop rate is therefore one byte per 2 cycles.
- **Full, then pop at edge M:** `uart_out_ready` returns high in the cycle after M, and a new push may occur at edge M+1.
- **Ready dependency:** `uart_out_ready` does not depend on `uart_out_valid`.

## Configuration
- `USB_RX_LINE_EN` defined:
  - `usb_rx_lines` is +1 on a push of `LINE_CHAR` and −1 on a pop of a byte equal to `LINE_CHAR`.
  - It is unchanged when both occur at the same edge.
  - It is cleared by flush and by reset.
- `USB_RX_LINE_EN` undefined: `usb_rx_lines` is tied to 0. No comparator or counter logic is synthesized. All other behaviour is identical.

## Test plan
- **Reset with read held high:** reset with `usb_rx_read` held 1, release reset, push 8'h41 → `usb_rx_valid`=1, `usb_rx_data`=8'h41, `usb_rx_count`=1, and no pop occurs until `usb_rx_read` goes 0→1.
- **Fill and wrap:** with `DEPTH_LOG2`=4, push 8'h00..8'h0F, then offer 8'h10 → `uart_out_ready`=0 and `usb_rx_count`=16. Then 16 read pulses return 8'h00..8'h0F in order, 8'h10 is accepted after the first pop, and the pointers wrap correctly.
- **Long read pulse:** hold `usb_rx_read` high for 100 cycles with 3 bytes buffered → exactly 1 byte popped, `usb_rx_count`=2.
- **Simultaneous push/pop:** at `usb_rx_count`=1, a pop edge and a push occur at the same edge → `usb_rx_count` stays 1, and `usb_rx_data` becomes the pushed byte.
- **Flush vs push:** assert `usb_rx_flush` while `uart_out_valid`=1 with 5 bytes buffered → `uart_out_ready`=0 that cycle, then `usb_rx_count`=0, `usb_rx_valid`=0, `usb_rx_data`=8'h00, and the offered byte is accepted on the next cycle.
- **Line counting (`USB_RX_LINE_EN`):** push "ab\ncd\n" → `usb_rx_lines`=2. Pop 3 bytes → `usb_rx_lines`=1. Without the macro, `usb_rx_lines` stays 0 throughout.
